// File: rtl/game_pkg.sv
// ============================================================================
// Module : game_pkg
// Purpose: Shared definitions for the game state controller: the game state
//          encoding, the lives ceiling and a counter-width helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int LIVES_MAX = 3;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rising_edge.sv
// ============================================================================
// Module : rising_edge
// Purpose: Registers the previous value of a level input and flags the cycle
//          on which the input is high while the stored previous value is low.
// Ports  : clk   - clock
//          reset - synchronous active-high reset (previous value <= RESET_VAL)
//          d     - level input
//          rise  - high when d=1 and registered previous d=0
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rising_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= RESET_VAL;
    else       prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/game_state_controller.sv
// ============================================================================
// Module : game_state_controller
// Purpose: Top-level game flow FSM: TITLE -> PLAY -> DYING -> RESPAWN/GAME_OVER.
//          Drives the mover reset, the motion freeze, remaining lives and an
//          optional death-flash request. All outputs are registered.
// Ports  : vga_clock    - single clock for all state
//          reset        - synchronous active-high reset
//          frame_tick   - one-cycle pulse per video frame
//          jump         - start/restart button (level)
//          lose         - Mario-hit-Goomba level
//          movers_reset - reset to the Mario and Goomba movers
//          freeze       - gameplay motion suspended
//          game_state   - current game_state_t encoding
//          lives        - remaining lives
//          flash        - sprite blank request during DYING
// Config : GAME_STATE_FLASH_EN - when defined, flash toggles every
//          FLASH_PERIOD frame_ticks in DYING; otherwise flash is tied to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module game_state_controller
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int GRACE_FRAMES = 30,
  parameter int FLASH_PERIOD = 8
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       jump,
  input  logic       lose,
  output logic       movers_reset,
  output logic       freeze,
  output logic [2:0] game_state,
  output logic [1:0] lives,
  output logic       flash
);

  localparam int DW = cnt_width(DEATH_FRAMES);
  localparam int GW = cnt_width(GRACE_FRAMES);
  localparam logic [1:0] LIVES_START =
    2'((LIVES_INIT > LIVES_MAX) ? LIVES_MAX : LIVES_INIT);

  game_state_t   state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [DW-1:0] frame_q, frame_d;
  logic [GW-1:0] grace_q, grace_d;
  logic          movers_reset_q, movers_reset_d;
  logic          freeze_q, freeze_d;
  logic          jump_press;

  // Previous jump resets to 1 so a button held through reset release
  // does not register as a press.
  rising_edge #(.RESET_VAL(1'b1)) u_jump_edge (
    .clk   (vga_clock),
    .reset (reset),
    .d     (jump),
    .rise  (jump_press)
  );

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q        <= TITLE;
      lives_q        <= LIVES_START;
      frame_q        <= '0;
      grace_q        <= '0;
      movers_reset_q <= 1'b1;
      freeze_q       <= 1'b1;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      frame_q        <= frame_d;
      grace_q        <= grace_d;
      movers_reset_q <= movers_reset_d;
      freeze_q       <= freeze_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    frame_d = frame_q;
    grace_d = grace_q;
    case (state_q)
      TITLE: begin
        if (jump_press) begin
          state_d = PLAY;
          grace_d = '0;
        end
      end
      PLAY: begin
        // The registered grace value decides, so a lose on the same cycle the
        // grace counter steps 1->0 is still ignored.
        if (lose && (grace_q == '0)) begin
          state_d = DYING;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          frame_d = '0;
        end else if (frame_tick && (grace_q != '0)) begin
          grace_d = grace_q - GW'(1);
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (frame_q != DW'(DEATH_FRAMES)) frame_d = frame_q + DW'(1);
          if (frame_q == DW'(DEATH_FRAMES - 1))
            state_d = (lives_q != 2'd0) ? RESPAWN : GAME_OVER;
        end
      end
      RESPAWN: begin
        state_d = PLAY;
        grace_d = GW'(GRACE_FRAMES);
      end
      GAME_OVER: begin
        lives_d = 2'd0;
        if (jump_press) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
    if (state_d == TITLE) lives_d = LIVES_START;
    movers_reset_d = (state_d == TITLE) || (state_d == RESPAWN);
    freeze_d       = (state_d != PLAY);
  end

  assign movers_reset = movers_reset_q;
  assign freeze       = freeze_q;
  assign game_state   = state_q;
  assign lives        = lives_q;

`ifdef GAME_STATE_FLASH_EN
  localparam int FW = cnt_width(FLASH_PERIOD - 1);

  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_q, flash_d;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
    end
  end

  // Flash phase only carries over while staying in DYING; any other next
  // state (including DYING entry) restarts it at zero.
  always_comb begin
    flash_cnt_d = '0;
    flash_d     = 1'b0;
    if ((state_q == DYING) && (state_d == DYING)) begin
      flash_cnt_d = flash_cnt_q;
      flash_d     = flash_q;
      if (frame_tick) begin
        if (flash_cnt_q == FW'(FLASH_PERIOD - 1)) begin
          flash_cnt_d = '0;
          flash_d     = ~flash_q;
        end else begin
          flash_cnt_d = flash_cnt_q + FW'(1);
        end
      end
    end
  end

  assign flash = flash_q;
`else
  assign flash = 1'b0;
`endif

endmodule

`default_nettype wire
